l1a_evt_queue: RTL

//  Downstream of the trigger stage: consumes the registered L1A, L1A_MATCH, RESYNC and BC0 strobes.

---
 rtl/l1a_evt_queue.sv | 124 ++++++++++++
 1 files changed

// File: rtl/l1a_evt_queue.sv
// L1A event counter, bunch-crossing counter and FWFT queue of {event number, BXN}
// for matched L1As, drained by the readout FSM through a ready/ack handshake.
`timescale 1ns / 100ps

module l1a_evt_queue #(
   parameter int unsigned DEPTH_LOG2 = 3,
   parameter int unsigned L1A_W      = 24,
   parameter int unsigned BXN_MAX    = 3563
) (
   input  logic                  CLK40,
   input  logic                  RST,
   input  logic                  L1A,
   input  logic                  L1A_MATCH,
   input  logic                  RESYNC,
   input  logic                  BC0,
   input  logic [11:0]           BC_OFFSET,
   output logic [L1A_W-1:0]      L1A_CNT,
   output logic                  EVT_RDY,
   output logic [L1A_W-1:0]      EVT_L1A_NUM,
   output logic [11:0]           EVT_BXN,
   input  logic                  EVT_ACK,
   output logic [DEPTH_LOG2:0]   QUEUE_CNT,
   output logic                  OVERFLOW
);

   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
   localparam int unsigned ENTRY_W = L1A_W + 12;
   localparam logic [11:0] BXN_LAST = 12'(BXN_MAX);
   localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] CNT_ONE = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
   localparam logic [L1A_W-1:0] L1A_ONE = L1A_W'(1);

   logic [11:0]           bxn_q;
   logic [L1A_W-1:0]      l1a_cnt_q;
   logic [L1A_W-1:0]      l1a_next;
   logic [ENTRY_W-1:0]    mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q;
   logic [DEPTH_LOG2-1:0] rd_ptr_q;
   logic [DEPTH_LOG2:0]   cnt_q;
   logic                  overflow_q;
   logic                  empty;
   logic                  full;
   logic                  push_req;
   logic                  push;
   logic                  pop;

   always_comb begin
      l1a_next = l1a_cnt_q + L1A_ONE;
      empty    = (cnt_q == '0);
      full     = (cnt_q == CNT_FULL);
      push_req = L1A & L1A_MATCH & ~RESYNC;
      pop      = EVT_ACK & ~empty & ~RESYNC;
      // A pop frees the slot the same edge, so a push into a full queue still fits
      push     = push_req & (~full | pop);
   end

   always_ff @(posedge CLK40 or posedge RST) begin
      if (RST) begin
         bxn_q <= '0;
      end else if (BC0) begin
         bxn_q <= BC_OFFSET;
      end else if (RESYNC) begin
         bxn_q <= '0;
      end else if (bxn_q == BXN_LAST) begin
         bxn_q <= '0;
      end else begin
         bxn_q <= bxn_q + 12'd1;
      end
   end

   always_ff @(posedge CLK40 or posedge RST) begin
      if (RST) begin
         l1a_cnt_q <= '0;
      end else if (RESYNC) begin
         l1a_cnt_q <= '0;
      end else if (L1A) begin
         l1a_cnt_q <= l1a_next;
      end
   end

   always_ff @(posedge CLK40 or posedge RST) begin
      if (RST) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         overflow_q <= 1'b0;
      end else if (RESYNC) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         if (push && !pop) begin
            cnt_q <= cnt_q + CNT_ONE;
         end else if (pop && !push) begin
            cnt_q <= cnt_q - CNT_ONE;
         end
         if (push_req && full && !pop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Storage needs no reset: the head is masked to zero while the queue is empty
   always_ff @(posedge CLK40) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {l1a_next, bxn_q};
      end
   end

   assign L1A_CNT   = l1a_cnt_q;
   assign EVT_RDY   = ~empty;
   assign QUEUE_CNT = cnt_q;
   assign OVERFLOW  = overflow_q;
   assign {EVT_L1A_NUM, EVT_BXN} = empty ? '0 : mem_q[rd_ptr_q];

endmodule
